// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller that merges NSRC peripheral
// requests onto a single CP0 interrupt input. Sources are synchronised,
// latched as edge or level, masked, and resolved by fixed priority with
// nesting (a source can only pre-empt handlers of lower priority).
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            we,
  input  logic            re,
  input  logic [2:0]      a,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic            irq
);

  localparam logic [2:0] A_PENDING   = 3'd0;
  localparam logic [2:0] A_ENABLE    = 3'd1;
  localparam logic [2:0] A_EDGE      = 3'd2;
  localparam logic [2:0] A_CLAIM     = 3'd3;
  localparam logic [2:0] A_COMPLETE  = 3'd4;
  localparam logic [2:0] A_INSERVICE = 3'd5;

  // Source path: two synchroniser flops, then one delay flop for edge detect
  logic [NSRC-1:0] sync_p0;
  logic [NSRC-1:0] sync_p1;
  logic [NSRC-1:0] dly_p2;

  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] inservice;

  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] edge_chg;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] cmp_clr;
  logic [NSRC-1:0] pend_next;
  logic            win_found;
  logic [4:0]      win_idx;
  logic            blocked;
  logic            claim_fire;
  logic            unused_wd;

  assign eligible   = pending & enable;
  assign rise       = sync_p1 & ~dly_p2;
  assign w1c        = (we && a == A_PENDING) ? wd[NSRC-1:0] : '0;
  assign edge_chg   = (we && a == A_EDGE) ? (edge_mode ^ wd[NSRC-1:0]) : '0;
  assign claim_fire = re && (a == A_CLAIM) && win_found;
  assign unused_wd  = ^wd;

  // Priority: lowest eligible index strictly above (numerically below) the
  // highest-priority source currently in service.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (inservice[i]) blocked = 1'b1;
      if (!blocked && eligible[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = 5'(i);
      end
    end
  end

  // Per-source claim/complete decode and next pending state; a fresh edge
  // beats a same-cycle W1C or claim, and an EDGE mode change drops the bit.
  always_comb begin
    claim_hit = '0;
    cmp_clr   = '0;
    pend_next = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i] = claim_fire && (win_idx == 5'(i));
      cmp_clr[i]   = we && (a == A_COMPLETE) && (wd[7:0] == 8'(i + 1));
      if (edge_mode[i])
        pend_next[i] = (pending[i] & ~w1c[i] & ~claim_hit[i]) | rise[i];
      else
        pend_next[i] = sync_p1[i];
      if (edge_chg[i]) pend_next[i] = 1'b0;
    end
  end

  // Register read mux; unimplemented bits and addresses read as zero
  always_comb begin
    rd = '0;
    case (a)
      A_PENDING:   rd = 32'(pending);
      A_ENABLE:    rd = 32'(enable);
      A_EDGE:      rd = 32'(edge_mode);
      A_CLAIM:     rd = win_found ? {27'd0, win_idx + 5'd1} : 32'd0;
      A_INSERVICE: rd = 32'(inservice);
      default:     rd = '0;
    endcase
  end

  // All controller state, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      dly_p2    <= '0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      inservice <= '0;
      irq       <= 1'b0;
    end else begin
      sync_p0   <= src;
      sync_p1   <= sync_p0;
      dly_p2    <= sync_p1;
      pending   <= pend_next;
      if (we && a == A_ENABLE) enable <= wd[NSRC-1:0];
      if (we && a == A_EDGE) edge_mode <= wd[NSRC-1:0];
      inservice <= (inservice | claim_hit) & ~cmp_clr;
      irq       <= win_found;
    end
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller sharing one CP0 hardware interrupt line among NSRC peripheral requesters.
- Synchronises, latches and masks the sources, and resolves fixed priority with nesting.
- Drives a registered request bit into one of CP0's int[5:0] inputs.
- The handler uses CLAIM and COMPLETE registers to identify and retire each source.

Parameters:
NSRC, 8, number of interrupt sources (1..16); source 0 has the highest priority.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
src  in  NSRC  raw asynchronous interrupt requests from peripherals
we  in  1  bus write strobe, one cycle
re  in  1  bus read strobe, one cycle; qualifies CLAIM side effects only
a  in  3  word address of the register
wd  in  32  bus write data
rd  out  32  bus read data, combinational from a and current state
irq  out  1  registered request, wired to one CP0 int bit

Behaviour:
Registers by address; unimplemented bits read 0; any other address reads 0 and ignores writes.
- 0 PENDING: W1C, edge bits only.
- 1 ENABLE: RW.
- 2 EDGE: RW; 1 = rising-edge source, 0 = level source.
- 3 CLAIM: RO with side effect.
- 4 COMPLETE: WO.
- 5 INSERVICE: RO.

Reset (reset low, asynchronous):
- Clears synchronisers, pending, enable, edge and inservice.
- irq = 0.
- Asserting reset mid-handler drops all in-service state.

Source path:
- 2-flop synchroniser per source, then one delay flop for edge detection.
- Edge sources: pending bit set when the sync output is 1 and the delayed copy is 0.
- Level sources: pending equals the sync output directly; W1C has no effect on it.
- Latency: a src change sampled at edge k appears in PENDING after edge k+2, and on irq after edge k+3.

Priority resolution (combinational):
- eligible = pending & enable.
- ceiling = lowest set index in inservice, or NSRC if inservice is empty.
- winner = lowest eligible index strictly below ceiling, if any.
- irq register <= winner exists, updated every cycle.

CLAIM (re=1, a=3):
- rd = winner+1, or 0 if no winner.
- At the same edge, if a winner exists: set inservice[winner], and clear pending[winner] if it is an edge source.
- A read without re has no side effect. A claim with no winner changes nothing.

COMPLETE (we=1, a=4):
- Let n = wd[7:0]. If 1 <= n <= NSRC, clear inservice[n-1].
- Otherwise ignore. Completing a source not in service is a no-op.

Collision rules:
- Edge detection at the same edge as a W1C or claim of that bit: the set wins, and the bit stays pending.
- ENABLE/EDGE writes take effect the next cycle. Changing EDGE clears that source's pending bit.
- Clearing ENABLE on an in-service source does not clear inservice.
- irq stays 0 for a level source held high while it is in service (not below the ceiling). It re-asserts after COMPLETE if the source is still high.

Test Plan:
1. Reset low mid-operation with inservice=0x04 and irq=1 -> immediately irq=0, rd of INSERVICE/ENABLE/PENDING = 0, no clock needed.
2. ENABLE=0x01, EDGE=0x01; pulse src[0] high for 1 cycle at edge k -> PENDING=0x01 after k+2, irq=1 after k+3; CLAIM read returns 1, next cycle PENDING=0, INSERVICE=0x01, irq=0.
3. Nesting: src[5] claimed (INSERVICE=0x20); then level src[2] and level src[6] go high -> irq=1, CLAIM returns 3, INSERVICE=0x24, irq=0; COMPLETE 3 with src[2] still high -> irq=1 again; drop src[2], COMPLETE 3, COMPLETE 6 -> CLAIM returns 7.
4. Level src[1] high, ENABLE=0x02, EDGE=0 -> write PENDING W1C 0x02 -> PENDING still 0x02; src[1] low -> PENDING 0 two edges later.
5. Edge src[3] rises at the same edge as W1C 0x08 of the previous pending bit -> PENDING bit 3 remains 1.
6. Edge: CLAIM with nothing eligible -> returns 0, state unchanged; COMPLETE with wd=0 and wd=NSRC+1 -> no change; write to a=7 ignored, reads 0.
